// File: rtl/blinky_button_ctrl.sv
// Avalon-MM push-button controller: 2-flop sync, per-bit debounce, press capture, irq.
// Optional irq mask/interrupt logic is enabled by defining BLINKY_BUTTON_CTRL_IRQ_EN.
module blinky_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [2:0]  in_port
);

    localparam int unsigned NB    = 3;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync_q;
    logic [NB-1:0]    deb_q;
    logic [NB-1:0]    deb_d;
    logic [NB-1:0]    edge_q;
    logic [NB-1:0]    edge_d;
    logic [NB-1:0]    press_c;
    logic [NB-1:0]    w1c_c;
    logic [NB-1:0]    mask_v;
    logic [31:0]      readdata_d;
    logic             wr_c;
    logic             unused_wdata_c;
    state_t           state_q [NB];
    state_t           state_d [NB];
    logic [CNT_W-1:0] cnt_q   [NB];
    logic [CNT_W-1:0] cnt_d   [NB];

    assign unused_wdata_c = ^writedata[31:NB];
    assign wr_c           = chipselect & ~write_n;

    // Two-flop synchronizer; idle (released) level is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync_q  <= '1;
        end else begin
            sync1_q <= in_port;
            sync_q  <= sync1_q;
        end
    end

    // Debounce, edge capture and read data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q    <= '1;
            edge_q   <= '0;
            readdata <= '0;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            deb_q    <= deb_d;
            edge_q   <= edge_d;
            readdata <= readdata_d;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-bit debounce FSM: a change is accepted after DEBOUNCE_CYCLES mismatching samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_q[i] != deb_q[i]) begin
                        state_d[i] = ST_COUNT;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (sync_q[i] == deb_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        deb_d[i]   = sync_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Press capture: a new press overrides a same-cycle clear.
    always_comb begin
        press_c = deb_q & ~deb_d;
        w1c_c   = '0;
        if (wr_c && address == 2'd3) begin
            w1c_c = writedata[NB-1:0];
        end
        edge_d = (edge_q & ~w1c_c) | press_c;
    end

`ifdef BLINKY_BUTTON_CTRL_IRQ_EN
    logic [NB-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_c && address == 2'd2) begin
                mask_q <= writedata[NB-1:0];
            end
            irq <= |(edge_q & mask_q);
        end
    end

    assign mask_v = mask_q;
`else
    assign mask_v = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(deb_q);
            2'd1:    readdata_d = 32'(sync_q);
            2'd2:    readdata_d = 32'(mask_v);
            default: readdata_d = 32'(edge_q);
        endcase
    end

endmodule

// File: tb/tb_blinky_button_ctrl.sv
// Self-checking bench for blinky_button_ctrl (DEBOUNCE_CYCLES=4); follows
// BLINKY_BUTTON_CTRL_IRQ_EN for mask/irq expectations.
module tb_blinky_button_ctrl;

`ifdef BLINKY_BUTTON_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [2:0]  in_port;

    blinky_button_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        bit          is_irq;
        string       name;
    } exp_t;

    typedef struct {
        bit          wr;
        bit          cs;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] mexp(input logic [31:0] v);
        return IRQ_EN ? (v & 32'h7) : 32'h0;
    endfunction

    function automatic void compare(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic push_rd(input logic [31:0] exp, input string name);
        exp_t e;
        e.exp = exp; e.is_irq = 1'b0; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_irq(input logic exp, input string name);
        exp_t e;
        e.exp = 32'(exp); e.is_irq = 1'b1; e.name = name;
        sb.push_back(e);
    endtask

    // Advance one clock, then retire every expectation queued for this cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.is_irq ? 32'(irq) : readdata, e.exp, e.name);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
        address = addr;
        push_rd(exp, name);
        tick();
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data, input bit cs);
        chipselect = cs;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Button-0 acceptance watch: deb visible on readdata one cycle after it updates.
    task automatic watch_accept0(input string name);
        address = 2'd0;
        for (int k = 0; k <= 6; k++) begin
            push_rd((k < 6) ? 32'h7 : 32'h6, name);
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0,        32'h7,          "idle_deb"};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 32'h0,        32'h7,          "idle_sync"};
        vecs[2] = '{1'b0, 1'b0, 2'd3, 32'h0,        32'h0,          "idle_edge"};
        vecs[3] = '{1'b1, 1'b1, 2'd2, 32'h5,        mexp(32'h5),    "mask_wr5"};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 32'h0,        32'h7,          "deb_ro"};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h7,          "sync_ro"};
        vecs[6] = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFFF, mexp(32'h7),    "mask_wr_all"};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 32'h0,        mexp(32'h7),    "mask_no_cs"};
        vecs[8] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0,          "mask_wr0"};
        vecs[9] = '{1'b1, 1'b1, 2'd3, 32'h7,        32'h0,          "edge_w1c_idle"};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 3'b111;

        // Reset state, held across several addresses.
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            push_rd(32'h0, "reset_rd");
            push_irq(1'b0, "reset_irq");
            tick();
        end
        reset_n = 1'b1;
        rd(2'd0, 32'h7, "post_reset_deb");
        rd(2'd2, 32'h0, "post_reset_mask");

        // Register map vectors.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) wr(vecs[v].addr, vecs[v].wdata, vecs[v].cs);
            address = vecs[v].addr;
            push_rd(vecs[v].exp, vecs[v].name);
            push_irq(1'b0, {vecs[v].name, "_irq"});
            tick();
        end

        // Held press on button 0: exact acceptance latency.
        in_port = 3'b110;
        watch_accept0("press0_deb");
        rd(2'd3, 32'h1, "press0_edge");
        rd(2'd0, 32'h6, "press0_deb_after");
        rd(2'd1, 32'h6, "press0_sync");
        in_port = 3'b111;
        ticks(8);
        rd(2'd0, 32'h7, "release0_deb");
        rd(2'd3, 32'h1, "release0_no_edge");
        wr(2'd3, 32'h1, 1'b1);
        rd(2'd3, 32'h0, "clear0_edge");

        // Short glitch on button 1 is rejected.
        in_port = 3'b101;
        ticks(3);
        in_port = 3'b111;
        ticks(6);
        rd(2'd0, 32'h7, "glitch1_deb");
        push_irq(1'b0, "glitch1_irq");
        rd(2'd3, 32'h0, "glitch1_edge");

        // Masked interrupt on button 2.
        wr(2'd2, 32'h4, 1'b1);
        in_port = 3'b011;
        address = 2'd3;
        for (int k = 0; k <= 6; k++) begin
            push_rd((k >= 6) ? 32'h4 : 32'h0, "press2_edge");
            push_irq((k >= 6) && IRQ_EN, "press2_irq");
            tick();
        end
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
        push_rd(32'h4, "w1c2_edge_old");
        push_irq(IRQ_EN, "w1c2_irq_old");
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        push_rd(32'h0, "w1c2_edge");
        push_irq(1'b0, "w1c2_irq");
        tick();
        in_port = 3'b010;
        ticks(8);
        push_irq(1'b0, "press0_masked_irq");
        rd(2'd3, 32'h1, "press0_masked_edge");
        in_port = 3'b111;
        ticks(8);
        wr(2'd3, 32'h7, 1'b1);
        rd(2'd3, 32'h0, "clear_all_edge");

        // Same-cycle clear and press: set wins.
        in_port = 3'b110;
        ticks(5);
        wr(2'd3, 32'h1, 1'b1);
        rd(2'd3, 32'h1, "set_wins_edge");
        rd(2'd0, 32'h6, "set_wins_deb");
        in_port = 3'b111;
        ticks(8);
        wr(2'd3, 32'h1, 1'b1);
        rd(2'd3, 32'h0, "set_wins_clear");

        // Reset mid-count discards the pending press.
        in_port = 3'b110;
        ticks(4);
        reset_n = 1'b0;
        #2;
        compare(readdata, 32'h0, "async_reset_rd");
        compare(32'(irq), 32'h0, "async_reset_irq");
        address = 2'd0;
        for (int k = 0; k < 3; k++) begin
            push_rd(32'h0, "midcount_reset_rd");
            tick();
        end
        reset_n = 1'b1;
        watch_accept0("reset_accept0_deb");
        rd(2'd3, 32'h1, "reset_accept0_edge");
        rd(2'd2, 32'h0, "reset_mask");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
